// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue/hazard controller: int/float busy scoreboard, downstream stall and flush sequencing.
// decode_enable/stall are combinational; DECODE_ISSUE_BYPASS_EN lets a same-cycle writeback unblock issue.
module decode_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   inst_valid,
    input  logic [4:0]             src1_no,
    input  logic                   src1_f,
    input  logic                   src1_used,
    input  logic [4:0]             src2_no,
    input  logic                   src2_f,
    input  logic                   src2_used,
    input  logic [4:0]             dst_no,
    input  logic                   dst_f,
    input  logic                   dst_we,
    input  logic                   ex_ready,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_no,
    input  logic                   wb_f,
    input  logic                   flush,
    output logic                   decode_enable,
    output logic                   stall,
    output logic [1:0]             state,
    output logic [31:0]            busy_int,
    output logic [31:0]            busy_flt,
    output logic                   wb_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t                 state_q;
    logic [3:0]             fcnt_q;
    logic [31:0]            busy_int_q, busy_int_d;
    logic [31:0]            busy_flt_q, busy_flt_d;
    logic                   wb_err_q, wb_err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [31:0]            wb_clr_int, wb_clr_flt;
    logic [31:0]            busy_int_eff, busy_flt_eff;
    logic                   hazard;
    logic                   flushing;

    function automatic logic is_busy(input logic [31:0] bi, input logic [31:0] bf,
                                     input logic f, input logic [4:0] n);
        return f ? bf[n] : ((n != 5'd0) && bi[n]);
    endfunction

    always_comb begin
        wb_clr_int = '0;
        wb_clr_flt = '0;
        if (wb_valid) begin
            if (wb_f) wb_clr_flt[wb_no] = 1'b1;
            else      wb_clr_int[wb_no] = 1'b1;
        end
    end

`ifdef DECODE_ISSUE_BYPASS_EN
    // Register file writes through, so a register retiring this cycle is readable now.
    assign busy_int_eff = busy_int_q & ~wb_clr_int;
    assign busy_flt_eff = busy_flt_q & ~wb_clr_flt;
`else
    assign busy_int_eff = busy_int_q;
    assign busy_flt_eff = busy_flt_q;
`endif

    assign hazard = (src1_used && is_busy(busy_int_eff, busy_flt_eff, src1_f, src1_no))
                 || (src2_used && is_busy(busy_int_eff, busy_flt_eff, src2_f, src2_no))
                 || (dst_we    && is_busy(busy_int_eff, busy_flt_eff, dst_f,  dst_no));

    assign flushing      = (state_q == FLUSH);
    assign decode_enable = rstn && inst_valid && ex_ready && !hazard && !flush && !flushing;
    assign stall         = rstn && inst_valid && !decode_enable && !flush && !flushing;

    // Set after clear so a new writer issued in its predecessor's writeback cycle stays outstanding.
    always_comb begin
        busy_int_d = busy_int_q & ~wb_clr_int;
        busy_flt_d = busy_flt_q & ~wb_clr_flt;
        wb_err_d   = wb_err_q | (|(wb_clr_int & ~busy_int_q)) | (|(wb_clr_flt & ~busy_flt_q));
        if (decode_enable && dst_we) begin
            if (dst_f)                busy_flt_d[dst_no] = 1'b1;
            else if (dst_no != 5'd0)  busy_int_d[dst_no] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_int_q  <= '0;
            busy_flt_q  <= '0;
            wb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_int_q <= busy_int_d;
            busy_flt_q <= busy_flt_d;
            wb_err_q   <= wb_err_d;
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (flush) begin
                        state_q <= FLUSH;
                        fcnt_q  <= FLUSH_LOAD;
                    end else if (inst_valid && (hazard || !ex_ready)) begin
                        state_q <= STALL;
                    end
                end
                STALL: begin
                    if (flush) begin
                        state_q <= FLUSH;
                        fcnt_q  <= FLUSH_LOAD;
                    end else if (decode_enable) begin
                        state_q <= RUN;
                    end
                end
                FLUSH: begin
                    if (flush)               fcnt_q  <= FLUSH_LOAD;
                    else if (fcnt_q == 4'd0) state_q <= RUN;
                    else                     fcnt_q  <= fcnt_q - 4'd1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign state        = state_q;
    assign busy_int     = busy_int_q;
    assign busy_flt     = busy_flt_q;
    assign wb_err       = wb_err_q;
    assign stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus random traffic against a queue-based scoreboard.
`timescale 1ns/1ps
module tb_decode_issue_ctrl;
    localparam int FC  = 2;
    localparam int SCW = 4;
`ifdef DECODE_ISSUE_BYPASS_EN
    localparam int EXP_R5_STALLS = 3;
`else
    localparam int EXP_R5_STALLS = 4;
`endif

    logic clk = 1'b0;
    logic rstn;
    logic inst_valid, src1_f, src1_used, src2_f, src2_used, dst_f, dst_we;
    logic [4:0] src1_no, src2_no, dst_no, wb_no;
    logic ex_ready, wb_valid, wb_f, flush;
    logic decode_enable, stall, wb_err;
    logic [1:0] state;
    logic [31:0] busy_int, busy_flt;
    logic [SCW-1:0] stall_cycles;

    always #5 clk = ~clk;

    decode_issue_ctrl #(.FLUSH_CYCLES(FC), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rstn(rstn), .inst_valid(inst_valid),
        .src1_no(src1_no), .src1_f(src1_f), .src1_used(src1_used),
        .src2_no(src2_no), .src2_f(src2_f), .src2_used(src2_used),
        .dst_no(dst_no), .dst_f(dst_f), .dst_we(dst_we),
        .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_no(wb_no), .wb_f(wb_f),
        .flush(flush), .decode_enable(decode_enable), .stall(stall), .state(state),
        .busy_int(busy_int), .busy_flt(busy_flt), .wb_err(wb_err), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit           de;
        bit           st;
        bit [1:0]     state;
        bit [31:0]    bi;
        bit [31:0]    bf;
        bit           err;
        bit [SCW-1:0] sc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: plain arrays and a remaining-blocked-cycles count.
    bit m_busy_i[32];
    bit m_busy_f[32];
    int m_rem;
    bit m_stalled;
    bit m_err;
    int m_scnt;
    bit m_last_de;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("decode_enable", 64'(decode_enable), 64'(mon_e.de));
            chk("stall",         64'(stall),         64'(mon_e.st));
            chk("state",         64'(state),         64'(mon_e.state));
            chk("busy_int",      64'(busy_int),      64'(mon_e.bi));
            chk("busy_flt",      64'(busy_flt),      64'(mon_e.bf));
            chk("wb_err",        64'(wb_err),        64'(mon_e.err));
            chk("stall_cycles",  64'(stall_cycles),  64'(mon_e.sc));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_busy_i[i] = 1'b0;
            m_busy_f[i] = 1'b0;
        end
        m_rem = 0; m_stalled = 1'b0; m_err = 1'b0; m_scnt = 0; m_last_de = 1'b0;
    endtask

    function automatic bit m_isbusy(bit f, bit [4:0] n);
        bit b;
        b = f ? m_busy_f[n] : ((n != 5'd0) && m_busy_i[n]);
`ifdef DECODE_ISSUE_BYPASS_EN
        if (wb_valid && (wb_f == f) && (wb_no == n)) b = 1'b0;
`endif
        return b;
    endfunction

    // Called at posedge+1 with inputs driven: queue this cycle's expectation, advance model, cross the edge.
    task automatic step();
        exp_t e;
        bit haz, infl, de, st, raw;
        infl = (m_rem > 0);
        haz  = (src1_used && m_isbusy(src1_f, src1_no)) || (src2_used && m_isbusy(src2_f, src2_no))
            || (dst_we && m_isbusy(dst_f, dst_no));
        de = inst_valid && ex_ready && !haz && !flush && !infl;
        st = inst_valid && !de && !flush && !infl;
        e.de = de; e.st = st;
        e.state = infl ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
        for (int i = 0; i < 32; i++) begin
            e.bi[i] = m_busy_i[i];
            e.bf[i] = m_busy_f[i];
        end
        e.err = m_err;
        e.sc  = SCW'(m_scnt);
        expq.push_back(e);
        m_last_de = de;

        if (flush) begin
            m_rem = FC; m_stalled = 1'b0;
        end else if (infl) begin
            m_rem--;
        end else if (de) begin
            m_stalled = 1'b0;
        end else if (inst_valid && (haz || !ex_ready)) begin
            m_stalled = 1'b1;
        end
        if (wb_valid) begin
            raw = wb_f ? m_busy_f[wb_no] : ((wb_no != 5'd0) && m_busy_i[wb_no]);
            if (!raw)      m_err = 1'b1;
            else if (wb_f) m_busy_f[wb_no] = 1'b0;
            else           m_busy_i[wb_no] = 1'b0;
        end
        if (de && dst_we) begin
            if (dst_f)                m_busy_f[dst_no] = 1'b1;
            else if (dst_no != 5'd0)  m_busy_i[dst_no] = 1'b1;
        end
        if (st && m_scnt < (1 << SCW) - 1) m_scnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(bit v, bit s1f, bit [4:0] s1n, bit s1u, bit s2f, bit [4:0] s2n, bit s2u,
                            bit df, bit [4:0] dn, bit dwe);
        inst_valid = v;
        src1_f = s1f; src1_no = s1n; src1_used = s1u;
        src2_f = s2f; src2_no = s2n; src2_used = s2u;
        dst_f = df; dst_no = dn; dst_we = dwe;
    endtask

    task automatic set_wb(bit v, bit f, bit [4:0] n);
        wb_valid = v; wb_f = f; wb_no = n;
    endtask

    task automatic idle();
        set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        ex_ready = 1'b1;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    int k;
    int p;
    int pend[$];

    initial begin
        rstn = 1'b0;
        idle();
        model_reset();
        #2;
        chk("rst_state", 64'(state), 0);
        chk("rst_busy_int", 64'(busy_int), 0);
        chk("rst_busy_flt", 64'(busy_flt), 0);
        chk("rst_wb_err", 64'(wb_err), 0);
        chk("rst_stall_cycles", 64'(stall_cycles), 0);
        do_reset();

        // Reader of r5 waits for the writeback three cycles into its stall.
        set_inst(1, 0, 0, 0, 0, 0, 0, 0, 5, 1);
        step();
        set_inst(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        k = 0;
        do begin
            set_wb(k == 3, 0, 5);
            step();
            k++;
        end while (!m_last_de && k < 10);
        idle();
        chk("r5_issue_cycle", 64'(k - 1), 64'(EXP_R5_STALLS));
        chk("r5_stall_cycles", 64'(stall_cycles), 64'(EXP_R5_STALLS));

        // Reset asserted while stalled on a busy r5.
        set_inst(1, 0, 0, 0, 0, 0, 0, 0, 5, 1);
        step();
        set_inst(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("pre_reset_state", 64'(state), 1);
        chk("pre_reset_busy_r5", 64'(busy_int[5]), 1);
        set_inst(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_ready = 1'b1;
        rstn = 1'b0;
        #2;
        chk("midrst_state", 64'(state), 0);
        chk("midrst_busy_int", 64'(busy_int), 0);
        chk("midrst_decode_enable", 64'(decode_enable), 0);
        chk("midrst_stall", 64'(stall), 0);
        chk("midrst_stall_cycles", 64'(stall_cycles), 0);
        idle();
        do_reset();

        // Integer r0 is never tracked; float f0 is.
        set_inst(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("r0_not_busy", 64'(busy_int), 0);
        set_inst(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step();
        chk("r0_read_no_stall", 64'(state), 0);
        set_inst(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step();
        chk("f0_busy", 64'(busy_flt[0]), 1);
        set_inst(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("f0_read_stalls", 64'(state), 1);
        set_wb(1, 1, 0);
        step();
        set_wb(0, 0, 0);
        step();
        idle();
        step();

        // Flush for FC cycles, then a flush re-armed during FLUSH.
        set_inst(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_c0_state", 64'(state), 2);
        step();
        chk("flush_c1_state", 64'(state), 2);
        step();
        chk("flush_done_state", 64'(state), 0);
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        step();
        chk("reflush_state", 64'(state), 2);
        step();
        chk("reflush_done_state", 64'(state), 0);

        // Downstream not ready for three cycles.
        ex_ready = 1'b0;
        step();
        chk("exrdy_stall_state", 64'(state), 1);
        step();
        step();
        ex_ready = 1'b1;
        step();
        chk("exrdy_resume_state", 64'(state), 0);
        idle();

        // New f7 writer against an f7 writeback in the same cycle.
        set_inst(1, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        step();
        set_wb(1, 1, 7);
        step();
        set_wb(0, 0, 0);
        k = 0;
        while (!m_last_de && k < 5) begin
            step();
            k++;
        end
        idle();
        step();
        chk("f7_still_busy", 64'(busy_flt[7]), 1);
        chk("f7_no_err", 64'(wb_err), 0);

        // Writeback to a register nobody is writing.
        set_wb(1, 0, 9);
        step();
        set_wb(0, 0, 0);
        chk("r9_wb_err", 64'(wb_err), 1);
        step();
        step();
        chk("r9_wb_err_sticky", 64'(wb_err), 1);

        idle();
        do_reset();

        for (int c = 0; c < 1500; c++) begin
            inst_valid = ($urandom_range(99) < 75);
            src1_no = 5'($urandom_range(7)); src1_f = 1'($urandom_range(1)); src1_used = 1'($urandom_range(1));
            src2_no = 5'($urandom_range(7)); src2_f = 1'($urandom_range(1)); src2_used = 1'($urandom_range(1));
            dst_no  = 5'($urandom_range(7)); dst_f  = 1'($urandom_range(1)); dst_we    = 1'($urandom_range(1));
            ex_ready = ($urandom_range(99) < 80);
            flush    = ($urandom_range(99) < 5);
            pend.delete();
            for (int i = 0; i < 32; i++) begin
                if (m_busy_i[i]) pend.push_back(i);
                if (m_busy_f[i]) pend.push_back(32 + i);
            end
            if (pend.size() > 0 && $urandom_range(99) < 40) begin
                p = pend[$urandom_range(pend.size() - 1)];
                set_wb(1, p >= 32, 5'(p % 32));
            end else if ($urandom_range(99) < 2) begin
                set_wb(1, 1'($urandom_range(1)), 5'($urandom_range(7)));
            end else begin
                set_wb(0, 0, 0);
            end
            step();
        end
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Issue/hazard controller for the decode stage.
- Generates the decode register-capture enable every cycle from:
  - a per-register busy scoreboard covering the integer and float register files,
  - downstream readiness,
  - a branch-redirect flush sequence.
- Sits between fetch and decode. Consumes the source/destination fields decode already extracts and the writeback notifications from the register-file write port.

Parameters:
- FLUSH_CYCLES, 2, number of cycles decode stays disabled after a flush (range 1..15).
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- inst_valid  in  1  command at decode input is a valid instruction
- src1_no  in  5  first source register number
- src1_f  in  1  first source is in the float file
- src1_used  in  1  instruction reads source 1
- src2_no  in  5  second source register number
- src2_f  in  1  second source is in the float file
- src2_used  in  1  instruction reads source 2
- dst_no  in  5  destination register number
- dst_f  in  1  destination is in the float file
- dst_we  in  1  instruction writes a register
- ex_ready  in  1  next stage accepts an instruction this cycle
- wb_valid  in  1  register writeback this cycle
- wb_no  in  5  writeback register number
- wb_f  in  1  writeback targets the float file
- flush  in  1  branch redirect; squash the instruction at decode
- decode_enable  out  1  combinational; capture enable for decode registers
- stall  out  1  combinational; inst_valid high but not issued, and not flushing
- state  out  2  registered FSM state: RUN=0, STALL=1, FLUSH=2
- busy_int  out  32  registered integer scoreboard
- busy_flt  out  32  registered float scoreboard
- wb_err  out  1  registered, sticky; writeback to a non-busy register
- stall_cycles  out  STALL_CNT_W  registered saturating count of stall cycles

Behaviour:
- Reset (rstn low, asynchronous):
  - state=RUN, busy_int=0, busy_flt=0, wb_err=0, stall_cycles=0, flush counter=0.
  - decode_enable and stall are forced 0 while rstn is low.
- Hazard is true when any of the following holds:
  - src1_used and the register selected by (src1_f, src1_no) is busy;
  - src2_used and the register selected by (src2_f, src2_no) is busy;
  - dst_we and the register selected by (dst_f, dst_no) is busy (WAW).
- Integer register 0 is never busy: it is never set and always reads not-busy. Float register 0 is tracked normally.
- decode_enable = inst_valid & ex_ready & ~hazard & ~flush & (state != FLUSH). Output is combinational, with zero latency to the decode enable.
- Scoreboard update at the clock edge:
  - Set: the destination bit is set when decode_enable & dst_we.
  - Clear: the (wb_f, wb_no) bit is cleared when wb_valid.
  - Same bit set and cleared in one cycle: set wins (new writer outstanding).
  - wb_valid to a bit that is already 0: wb_err goes to 1 and stays there until reset. The scoreboard is unchanged.
- FSM:
  - RUN → FLUSH on flush; the counter loads FLUSH_CYCLES-1.
  - RUN → STALL when inst_valid & (hazard | ~ex_ready) and no flush.
  - STALL → RUN when decode_enable is 1 in that cycle.
  - STALL → FLUSH on flush; the stalled instruction is dropped.
  - FLUSH: decode_enable=0. The counter decrements each cycle; at counter 0 go to RUN.
  - flush while in FLUSH reloads the counter.
- flush has priority over issue and stall in every state.
- The scoreboard is not cleared by flush: older in-flight writes still write back.
- stall = inst_valid & ~decode_enable & ~flush & (state != FLUSH). stall_cycles increments on each stall cycle and saturates at all-ones.
- Hazard evaluation uses pre-edge scoreboard contents only; a writeback in the same cycle does not unblock unless the optional feature is enabled.

Optional Feature:
- Macro: DECODE_ISSUE_BYPASS_EN.
- Defined: a source or destination whose busy bit is being cleared by wb_valid in the same cycle (matching number and file) counts as not busy. This allows issue in the writeback cycle; decode reads the write-through value from the register file.
- Undefined: such an instruction stalls exactly one extra cycle and issues the cycle after the writeback.

Test Plan:
- Reset mid-STALL with busy_int[5]=1 → immediately state=0, busy_int=0, decode_enable=0, stall_cycles=0.
- Issue dst int r5. Next instruction reads r5; wb r5 arrives 3 cycles later. Without the macro: stall=1 for 4 cycles, issue on the 5th, stall_cycles=4. With DECODE_ISSUE_BYPASS_EN: 3 stall cycles, stall_cycles=3.
- Issue dst int r0, then read r0 → no busy bit set, no stall. Float f0 as destination → busy_flt[0]=1 and a following read of f0 stalls.
- flush with FLUSH_CYCLES=2 while inst_valid=1 → decode_enable=0 for the flush cycle plus 2 FLUSH cycles, then RUN. A second flush during FLUSH extends the sequence by the reload.
- Same cycle: issue with dst f7 plus wb_valid to f7 (previously busy) → busy_flt[7] remains 1 and wb_err stays 0. A later wb_valid to r9 while not busy → wb_err=1, sticky.
- ex_ready=0 for 3 cycles with no hazard → state=STALL, stall=1 for 3 cycles. Issue happens on the cycle ex_ready rises, then RUN.
